// File: rtl/psum_drain_pkg.sv
// Shared constants, drain FSM state encoding and the int8 saturation helper
// for the PE-column drain (psum_drain).
package psum_drain_pkg;

    localparam int unsigned ACC_W   = 24;        // PE c_out width
    localparam int unsigned SUM_W   = ACC_W + 8; // per-element accumulator width
    localparam int unsigned OUT_W   = 8;         // requantized output width
    localparam int unsigned DEPTH   = 4;         // output FIFO entries
    localparam int unsigned NTILE_W = 4;
    localparam int unsigned NELEM_W = 8;
    localparam int unsigned SHIFT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PUSH  = 2'd2
    } drain_state_e;

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] val;
    } sat8_t;

    // Clamp a SUM_W+1 bit signed value to [-128,127], flagging when clamped.
    function automatic sat8_t sat8(input logic signed [SUM_W:0] x);
        sat8_t                   r;
        logic signed [SUM_W:0]   qmax;
        logic signed [SUM_W:0]   qmin;
        qmax  = {{(SUM_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
        qmin  = {{(SUM_W + 1 - OUT_W){1'b1}}, 1'b1, {(OUT_W - 1){1'b0}}};
        r.sat = 1'b0;
        r.val = x[OUT_W-1:0];
        if (x > qmax) begin
            r.sat = 1'b1;
            r.val = qmax[OUT_W-1:0];
        end else if (x < qmin) begin
            r.sat = 1'b1;
            r.val = qmin[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_drain_fifo.sv
// Small synchronous FIFO with registered storage.
// Ports: clk/rst_n; push+din write; pop read; full/empty status; head = oldest entry.
// A push while full is accepted only together with a pop in the same cycle.
module psum_drain_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Drain end of a PE column: accumulates ntile partial sums per output element,
// requantizes each element to int8 (round-half-up shift, saturate) and streams
// the results out through a small FIFO with valid/ready backpressure.
// Ports: cfg_* job setup (latched on an accepted cfg_start); psum_valid/ready/in
// input stream; out_valid/ready/data output stream; busy, done pulse, sticky sat_flag.
module psum_drain
    import psum_drain_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [NTILE_W-1:0]      cfg_ntile,
    input  logic [NELEM_W-1:0]      cfg_nelem,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic                    psum_valid,
    output logic                    psum_ready,
    input  logic [ACC_W-1:0]        psum_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag
);

    drain_state_e          state;
    drain_state_e          state_next;

    logic [NTILE_W-1:0]    ntile_q;
    logic [NELEM_W-1:0]    nelem_q;
    logic [SHIFT_W-1:0]    shift_q;
    logic [NTILE_W-1:0]    tile_cnt;
    logic [NELEM_W-1:0]    elem_cnt;
    logic [SUM_W-1:0]      acc;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;
    logic                  start_fire;
    logic                  psum_fire;
    logic                  last_tile;
    logic                  last_elem;

    logic signed [SUM_W:0] acc_ext;
    logic signed [SUM_W:0] rnd;
    logic signed [SUM_W:0] biased;
    logic signed [SUM_W:0] shifted;
    sat8_t                 q;

    assign last_tile = (tile_cnt == NTILE_W'(ntile_q - NTILE_W'(1)));
    assign last_elem = (elem_cnt == NELEM_W'(nelem_q - NELEM_W'(1)));
    assign psum_fire = psum_valid && psum_ready;
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_fire) state_next = ACCUM;
            ACCUM:   if (psum_fire && last_tile) state_next = PUSH;
            PUSH:    if (fifo_push) state_next = last_elem ? IDLE : ACCUM;
            default: state_next = IDLE;
        endcase
    end

    // State decode; a start is only honoured once the FIFO has drained too
    always_comb begin
        psum_ready = 1'b0;
        fifo_push  = 1'b0;
        busy       = (state != IDLE) || !fifo_empty;
        start_fire = cfg_start && (state == IDLE) && fifo_empty;
        case (state)
            ACCUM:   psum_ready = 1'b1;
            PUSH:    fifo_push  = !fifo_full || fifo_pop;
            default: ;
        endcase
    end

    // Requantize: bias by half an LSB of the shifted result, shift, clamp.
    // One extra bit keeps the rounding add from overflowing.
    always_comb begin
        acc_ext = {acc[SUM_W-1], acc};
        rnd     = '0;
        if (shift_q != '0) begin
            rnd = (SUM_W+1)'(1) << (shift_q - SHIFT_W'(1));
        end
        biased  = acc_ext + rnd;
        shifted = biased >>> shift_q;
        q       = sat8(shifted);
    end

    // Job config, accumulator, counters and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ntile_q  <= '0;
            nelem_q  <= '0;
            shift_q  <= '0;
            tile_cnt <= '0;
            elem_cnt <= '0;
            acc      <= '0;
            sat_flag <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= fifo_push && last_elem;
            if (start_fire) begin
                ntile_q  <= (cfg_ntile == '0) ? NTILE_W'(1) : cfg_ntile;
                nelem_q  <= (cfg_nelem == '0) ? NELEM_W'(1) : cfg_nelem;
                shift_q  <= cfg_shift;
                tile_cnt <= '0;
                elem_cnt <= '0;
                acc      <= '0;
                sat_flag <= 1'b0;
            end else if (psum_fire) begin
                acc      <= acc + {{(SUM_W - ACC_W){psum_in[ACC_W-1]}}, psum_in};
                tile_cnt <= tile_cnt + NTILE_W'(1);
            end else if (fifo_push) begin
                acc      <= '0;
                tile_cnt <= '0;
                elem_cnt <= elem_cnt + NELEM_W'(1);
                sat_flag <= sat_flag | q.sat;
            end
        end
    end

    psum_drain_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (q.val),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (out_data)
    );

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: hand-computed outputs, latency, backpressure,
// saturation, mid-job reset and ignored/zero configuration.
module tb_psum_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [3:0]  cfg_ntile;
    logic [7:0]  cfg_nelem;
    logic [4:0]  cfg_shift;
    logic        psum_valid;
    logic        psum_ready;
    logic [23:0] psum_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;
    logic        sat_flag;

    int n_chk = 0;
    int n_bad = 0;
    int got_q[$];
    int exp_q[$];
    int done_cnt = 0;

    psum_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_ntile  (cfg_ntile),
        .cfg_nelem  (cfg_nelem),
        .cfg_shift  (cfg_shift),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_in    (psum_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    // Record accepted outputs and done pulses away from the rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back(int'($signed(out_data)));
            if (done) done_cnt++;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int nt, input int ne, input int sh);
        cfg_ntile = 4'(nt);
        cfg_nelem = 8'(ne);
        cfg_shift = 5'(sh);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic push_psum(input int v);
        int n = 0;
        psum_valid = 1'b1;
        psum_in    = 24'(v);
        while (!psum_ready && n < 50) begin
            tick();
            n++;
        end
        if (!psum_ready) check_val("psum_ready_timeout", int'(psum_ready), 1);
        tick();
        psum_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check_val({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic check_outs(input string tag);
        check_val({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_val($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic new_test();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_start  = 1'b0;
        cfg_ntile  = '0;
        cfg_nelem  = '0;
        cfg_shift  = '0;
        psum_valid = 1'b0;
        psum_in    = '0;
        out_ready  = 1'b0;
        repeat (3) tick();

        // Reset state
        check_val("rst_psum_ready", int'(psum_ready), 0);
        check_val("rst_out_valid",  int'(out_valid), 0);
        check_val("rst_out_data",   int'(out_data), 0);
        check_val("rst_busy",       int'(busy), 0);
        check_val("rst_done",       int'(done), 0);
        check_val("rst_sat",        int'(sat_flag), 0);
        rst_n = 1'b1;
        tick();

        // T1: single psum passes through, latency t+2
        new_test();
        start_job(1, 1, 0);
        check_val("t1_ready", int'(psum_ready), 1);
        push_psum(100);
        check_val("t1_valid_t1", int'(out_valid), 0);
        tick();
        check_val("t1_valid_t2", int'(out_valid), 1);
        check_val("t1_data", int'($signed(out_data)), 100);
        check_val("t1_done", int'(done), 1);
        check_val("t1_sat", int'(sat_flag), 0);
        out_ready = 1'b1;
        tick();
        check_val("t1_busy_end", int'(busy), 0);
        check_val("t1_done_end", int'(done), 0);

        // T2: 3-tile accumulation, shift 2 with round-half-up
        new_test();
        start_job(3, 2, 2);
        push_psum(5);  push_psum(6);  push_psum(7);
        push_psum(-5); push_psum(-6); push_psum(-7);
        wait_idle("t2");
        exp_q = {5, -4};
        check_outs("t2");
        check_val("t2_done_cnt", done_cnt, 1);
        check_val("t2_sat", int'(sat_flag), 0);

        // T3: saturation both ways, sticky flag cleared on next start
        new_test();
        start_job(1, 2, 0);
        push_psum(300);
        push_psum(-300);
        wait_idle("t3");
        exp_q = {127, -128};
        check_outs("t3");
        check_val("t3_sat", int'(sat_flag), 1);
        new_test();
        start_job(1, 1, 0);
        check_val("t3_sat_clr", int'(sat_flag), 0);
        push_psum(7);
        wait_idle("t3b");
        exp_q = {7};
        check_outs("t3b");

        // T4: backpressure fills the FIFO and stalls the FSM in PUSH
        new_test();
        out_ready = 1'b0;
        start_job(1, 8, 0);
        for (int i = 1; i <= 5; i++) push_psum(i);
        repeat (3) tick();
        check_val("t4_stall_ready", int'(psum_ready), 0);
        check_val("t4_stall_valid", int'(out_valid), 1);
        check_val("t4_head", int'($signed(out_data)), 1);
        check_val("t4_busy", int'(busy), 1);
        check_val("t4_no_done", done_cnt, 0);
        out_ready = 1'b1;
        for (int i = 6; i <= 8; i++) push_psum(i);
        wait_idle("t4");
        exp_q = {1, 2, 3, 4, 5, 6, 7, 8};
        check_outs("t4");
        check_val("t4_done_cnt", done_cnt, 1);

        // T5: reset mid-job with an element waiting in the FIFO
        new_test();
        out_ready = 1'b0;
        start_job(3, 2, 0);
        push_psum(1); push_psum(1); push_psum(1);
        push_psum(10); push_psum(20);
        tick();
        check_val("t5_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_ready", int'(psum_ready), 0);
        check_val("t5_rst_valid", int'(out_valid), 0);
        check_val("t5_rst_data",  int'(out_data), 0);
        check_val("t5_rst_busy",  int'(busy), 0);
        check_val("t5_rst_done",  int'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        new_test();
        out_ready = 1'b1;
        start_job(1, 1, 0);
        push_psum(42);
        wait_idle("t5");
        exp_q = {42};
        check_outs("t5");

        // T6a: start pulsed mid-accumulation is ignored
        new_test();
        start_job(2, 1, 0);
        push_psum(3);
        start_job(1, 1, 0);
        push_psum(4);
        wait_idle("t6a");
        exp_q = {7};
        check_outs("t6a");

        // T6b: start while IDLE but FIFO non-empty is ignored
        new_test();
        out_ready = 1'b0;
        start_job(1, 1, 0);
        push_psum(9);
        tick();
        check_val("t6b_busy", int'(busy), 1);
        start_job(1, 1, 3);
        check_val("t6b_ignored", int'(psum_ready), 0);
        out_ready = 1'b1;
        wait_idle("t6b");
        exp_q = {9};
        check_outs("t6b");

        // T6c: zero ntile/nelem behave as 1
        new_test();
        start_job(0, 0, 0);
        push_psum(55);
        check_val("t6c_ready_after", int'(psum_ready), 0);
        wait_idle("t6c");
        exp_q = {55};
        check_outs("t6c");
        check_val("t6c_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
